// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback-path types: pipeline writeback record, LLU result record and
// the write-port arbiter state encoding.
package riscv_structures;

   localparam int REG_AW = 5;
   localparam int XLEN   = 32;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic [XLEN-1:0]   data;
   } mem_to_wb_s;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } llu_wb_s;

   typedef enum logic {
      NORMAL = 1'b0,
      FORCE  = 1'b1
   } wbarb_state_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback-port bundle: pipeline and LLU result inputs, hazard lookups and the
// register-file write port. The slave modport is the arbiter side.
interface wb_port_arbiter_if;
   import riscv_structures::*;

   mem_to_wb_s        mem_to_wb;
   logic              llu_valid;
   logic [REG_AW-1:0] llu_rd;
   logic [XLEN-1:0]   llu_data;
   logic              llu_ready;
   logic              llu_issue;
   logic [REG_AW-1:0] llu_issue_rd;
   logic [REG_AW-1:0] rs1_addr;
   logic [REG_AW-1:0] rs2_addr;
   logic              rs1_busy;
   logic              rs2_busy;
   logic              stall_pipe;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [XLEN-1:0]   rf_wdata;

   modport master (
      output mem_to_wb, llu_valid, llu_rd, llu_data, llu_issue, llu_issue_rd,
             rs1_addr, rs2_addr,
      input  llu_ready, rs1_busy, rs2_busy, stall_pipe, rf_we, rf_waddr, rf_wdata
   );

   modport slave (
      input  mem_to_wb, llu_valid, llu_rd, llu_data, llu_issue, llu_issue_rd,
             rs1_addr, rs2_addr,
      output llu_ready, rs1_busy, rs2_busy, stall_pipe, rf_we, rf_waddr, rf_wdata
   );

endinterface

// File: rtl/wb_port_arbiter_scoreboard.sv
// Busy scoreboard of pending LLU destinations with one set port, one clear port
// and two combinational read ports. A same-cycle set and clear of one bit keeps it set.
module wb_scoreboard
   import riscv_structures::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_en,
   input  logic [REG_AW-1:0] set_idx,
   input  logic              clr_en,
   input  logic [REG_AW-1:0] clr_idx,
   input  logic [REG_AW-1:0] rd_addr0,
   input  logic [REG_AW-1:0] rd_addr1,
   output logic              rd_busy0,
   output logic              rd_busy1,
   output logic [31:0]       busy
);

   logic [31:0] busy_q;
   logic [31:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      if (clr_en) busy_d[clr_idx] = 1'b0;
      if (set_en) busy_d[set_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign rd_busy0 = busy_q[rd_addr0];
   assign rd_busy1 = busy_q[rd_addr1];
   assign busy     = busy_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the in-order pipeline and one LLU, with
// starvation forcing and an LLU busy scoreboard. WB_PORT_ARBITER_PERF_EN adds perf counters.
module wb_port_arbiter
   import riscv_structures::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   wb_port_arbiter_if.slave  bus
`ifdef WB_PORT_ARBITER_PERF_EN
   ,
   output logic [31:0]       perf_conflict,
   output logic [31:0]       perf_force
`endif
);

   wbarb_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             pipe_wr;
   logic             llu_sel;
   logic             llu_xfer;
   logic [31:0]      sb_busy;
   llu_wb_s          llu_res;

   assign pipe_wr  = bus.mem_to_wb.reg_write && (bus.mem_to_wb.rd != '0);
   assign llu_res  = '{rd: bus.llu_rd, data: bus.llu_data};
   assign cnt_inc  = cnt_q + CNT_W'(1);
   assign llu_xfer = bus.llu_valid && bus.llu_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= NORMAL;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are forced quiet while reset is held, even if the state is still FORCE.
   always_comb begin
      bus.llu_ready  = 1'b0;
      bus.stall_pipe = 1'b0;
      bus.rf_we      = 1'b0;
      bus.rf_waddr   = bus.mem_to_wb.rd;
      bus.rf_wdata   = bus.mem_to_wb.data;
      llu_sel        = 1'b0;
      state_d        = NORMAL;
      cnt_d          = cnt_q;
      if (rst_n) begin
         if (state_q == FORCE) begin
            bus.stall_pipe = 1'b1;
            llu_sel        = 1'b1;
         end else if (!pipe_wr) begin
            llu_sel        = 1'b1;
         end
         if (llu_sel) begin
            bus.llu_ready = bus.llu_valid;
            bus.rf_we     = bus.llu_valid && (llu_res.rd != '0);
            bus.rf_waddr  = llu_res.rd;
            bus.rf_wdata  = llu_res.data;
         end else begin
            bus.rf_we     = 1'b1;
         end
      end
      if (state_q == NORMAL) begin
         if (llu_xfer || !bus.llu_valid) begin
            cnt_d = '0;
         end else if (pipe_wr) begin
            if (cnt_inc == CNT_W'(STARVE_LIMIT)) begin
               state_d = FORCE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_inc;
            end
         end
      end else begin
         cnt_d = '0;
      end
   end

   wb_scoreboard u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (bus.llu_issue && (bus.llu_issue_rd != '0)),
      .set_idx  (bus.llu_issue_rd),
      .clr_en   (llu_xfer),
      .clr_idx  (bus.llu_rd),
      .rd_addr0 (bus.rs1_addr),
      .rd_addr1 (bus.rs2_addr),
      .rd_busy0 (bus.rs1_busy),
      .rd_busy1 (bus.rs2_busy),
      .busy     (sb_busy)
   );

`ifdef WB_PORT_ARBITER_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_conflict <= '0;
         perf_force    <= '0;
      end else begin
         if (bus.llu_valid && pipe_wr && (perf_conflict != '1))
            perf_conflict <= perf_conflict + 32'd1;
         if ((state_q == NORMAL) && (state_d == FORCE) && (perf_force != '1))
            perf_force <= perf_force + 32'd1;
      end
   end
`endif

   // The LLU must hold its result through the forced cycle; WAW on a busy rd is illegal.
   a_force_valid : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == FORCE) |-> bus.llu_valid)
      else $error("llu_valid dropped during forced LLU writeback");

   a_no_waw : assert property (@(posedge clk) disable iff (!rst_n)
      (pipe_wr && (state_q == NORMAL)) |-> !sb_busy[bus.mem_to_wb.rd])
      else $error("pipeline write to register with pending LLU result");

endmodule
